// File: rtl/button_edge_detect.sv
// rtl/button_edge_detect.sv - push-button synchronizer, debouncer and edge-strobe generator
module button_edge_detect #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic r_edge,
    output logic f_edge,
    output logic btn_level
);

    // Raw pin level that means "not pressed"; also the synchronizer reset value.
    localparam logic IDLE_RAW = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             s0;
    logic             s1;
    logic             samp;
    logic             r_nxt;
    logic             f_nxt;
    logic             level_nxt;

    assign samp = s1 ^ IDLE_RAW;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= IDLE_RAW;
            s1 <= IDLE_RAW;
        end else begin
            s0 <= btn_in;
            s1 <= s0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE_LO;
            cnt       <= '0;
            r_edge    <= 1'b0;
            f_edge    <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            r_edge    <= r_nxt;
            f_edge    <= f_nxt;
            btn_level <= level_nxt;
        end
    end

    // cnt holds the number of consecutive samples that disagree with the accepted level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        r_nxt     = 1'b0;
        f_nxt     = 1'b0;
        case (state)
            IDLE_LO: begin
                if (samp) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (!samp) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE_LO;
                end else if (cnt == THRESH) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE_HI;
                    r_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!samp) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (samp) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE_HI;
                end else if (cnt == THRESH) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE_LO;
                    f_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE_LO;
            end
        endcase
        level_nxt = (state_nxt == IDLE_HI) || (state_nxt == WAIT_LO);
    end

endmodule
